fft_band_peak_finder: RTL
=========================

// Module: fft_band_peak_finder
// PURPOSE
//   Consumes one FFT frame as a stream of (bin index, magnitude) pairs and tracks the
//   strongest bin in each of NUM_BANDS equal-width frequency bands. At end of frame it
//   publishes all bands as {bin_index, magnitude} words with a one-cycle strobe. It sits
//   directly upstream of the PISO: maxima_flat drives PISO data_in, maxima_valid drives load.
// PARAMETERS
//   NUM_BANDS   16  number of bands / output entries
//   BIN_W       9   bin index width (512 bins per frame)
//   MAG_W       16  magnitude width, unsigned
//   BAND_SHIFT  5   log2(bins per band); band = bin_index >> BAND_SHIFT
// PORTS
//   clk           in   1                         system clock (50 MHz domain)
//   reset         in   1                         synchronous, active-high
//   bin_valid     in   1                         bin_index/bin_mag/sop/eop qualified this cycle
//   bin_sop       in   1                         first bin of frame (qualified by bin_valid)
//   bin_eop       in   1                         last bin of frame (qualified by bin_valid)
//   bin_index     in   BIN_W                     FFT bin number
//   bin_mag       in   MAG_W                     bin magnitude
//   mag_thresh    in   MAG_W                     bins with mag < thresh are ignored
//   maxima_flat   out  NUM_BANDS*(BIN_W+MAG_W)   entry k at [k*25 +: 25] = {idx[8:0], mag[15:0]}
//   maxima_valid  out  1                         1-cycle pulse: maxima_flat updated
//   frame_abort   out  1                         1-cycle pulse: partial frame discarded
// BEHAVIOUR
//   Reset: maxima_flat=0, maxima_valid=0, frame_abort=0, working regs=0, state=IDLE.
//   States: IDLE (wait for sop), ACCUM (in frame), PUBLISH (one cycle).
//   IDLE: bin_valid&bin_sop -> clear all working entries to 0, process this bin, go ACCUM.
//     bins with no sop are dropped silently.
//   ACCUM: each bin_valid bin with bin_mag >= mag_thresh and bin_mag > working_mag[band]
//     replaces working entry {bin_index, bin_mag}. Strict '>': ties keep the earlier bin.
//     Working entries are cleared to 0, so a bin with bin_mag == 0 never replaces an entry.
//   Band index uses only the low log2(NUM_BANDS) bits of bin_index>>BAND_SHIFT (wraps).
//   sop in ACCUM: discard partial frame, pulse frame_abort next cycle, clear working
//     entries, process the sop bin as the first bin of the new frame, stay ACCUM.
//   eop (bin_valid) in ACCUM or with sop in IDLE: process bin, go PUBLISH.
//   PUBLISH: maxima_flat <= working regs (including the eop bin's update); maxima_valid=1
//     for this one cycle; next state IDLE. bin_valid during PUBLISH is dropped. If it carries
//     sop, the new frame starts one cycle late and frame_abort is not pulsed.
//   Latency: eop accepted in cycle N -> maxima_valid=1 and new maxima_flat in cycle N+1.
//   sop&eop on one beat: single-bin frame, published next cycle.
//   maxima_flat holds its value between publishes; it never changes without maxima_valid.
//   Bands with no qualifying bin publish as 25'd0.
//   reset mid-frame: back to IDLE, no maxima_valid or frame_abort pulse, maxima_flat=0.
//   No backpressure: upstream frames are >= 2 cycles apart; downstream PISO must accept load.
// TESTING
//   1. Frame of bins 0..511, mag=bin_index, thresh=0 -> entry k = {32k+31, 32k+31};
//      maxima_valid pulses exactly once, 1 cycle after eop.
//   2. Tie: bin 40 mag 100 then bin 45 mag 100, thresh 0 -> entry 1 = {9'd40, 16'd100}.
//   3. thresh=500, all mags 499 except bin 300 mag 500 -> only entry 9 = {300,500}, rest 0.
//   4. sop at bin 0, then sop again at bin 100 of the same stream -> frame_abort pulses once;
//      bins 0..99 of the aborted frame absent from the published result.
//   5. Assert reset at bin 200 mid-frame -> no maxima_valid; maxima_flat=0; next full frame
//      publishes correctly.
//   6. Back-to-back frames with different peaks -> maxima_flat changes only on pulse cycles;
//      PISO+FIFO chain downstream emits the 16 bin indices in entry order.

Source files
------------

// File: rtl/fft_band_peak_finder.sv
// Per-band peak tracker for one FFT frame; publishes {bin_index, magnitude} for every band
// one cycle after end of frame, as a parallel load word for the downstream PISO.
module fft_band_peak_finder #(
    parameter int NUM_BANDS  = 16,
    parameter int BIN_W      = 9,
    parameter int MAG_W      = 16,
    parameter int BAND_SHIFT = 5
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 bin_valid,
    input  logic                                 bin_sop,
    input  logic                                 bin_eop,
    input  logic [BIN_W-1:0]                     bin_index,
    input  logic [MAG_W-1:0]                     bin_mag,
    input  logic [MAG_W-1:0]                     mag_thresh,
    output logic [NUM_BANDS*(BIN_W+MAG_W)-1:0]   maxima_flat,
    output logic                                 maxima_valid,
    output logic                                 frame_abort
);

    localparam int BAND_W  = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
    localparam int ENTRY_W = BIN_W + MAG_W;
    localparam int FLAT_W  = NUM_BANDS * ENTRY_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_PUBLISH = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_next_s;

    logic                 clear_s;
    logic                 process_s;
    logic                 publish_s;
    logic                 abort_s;
    logic [BAND_W-1:0]    band_s;
    logic                 qualified_s;

    logic [BIN_W-1:0]     work_idx_r      [NUM_BANDS];
    logic [MAG_W-1:0]     work_mag_r      [NUM_BANDS];
    logic [BIN_W-1:0]     work_idx_next_s [NUM_BANDS];
    logic [MAG_W-1:0]     work_mag_next_s [NUM_BANDS];
    logic [FLAT_W-1:0]    flat_next_s;

    logic [FLAT_W-1:0]    maxima_flat_r;
    logic                 maxima_valid_r;
    logic                 frame_abort_r;

    function automatic logic [ENTRY_W-1:0] pack_entry(input logic [BIN_W-1:0] idx,
                                                      input logic [MAG_W-1:0] mag);
        return {idx, mag};
    endfunction

    // Band select keeps only the low BAND_W bits of the shifted index, so oversized bins wrap.
    always_comb begin
        band_s      = BAND_W'(bin_index >> BAND_SHIFT);
        qualified_s = (bin_mag >= mag_thresh);
    end

    // Frame-control FSM: decides when working entries are cleared, updated and published.
    always_comb begin
        state_next_s = state_r;
        clear_s      = 1'b0;
        process_s    = 1'b0;
        publish_s    = 1'b0;
        abort_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bin_valid && bin_sop) begin
                    clear_s      = 1'b1;
                    process_s    = 1'b1;
                    publish_s    = bin_eop;
                    state_next_s = bin_eop ? ST_PUBLISH : ST_ACCUM;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (bin_valid) begin
                    process_s    = 1'b1;
                    clear_s      = bin_sop;
                    abort_s      = bin_sop;
                    publish_s    = bin_eop;
                    state_next_s = bin_eop ? ST_PUBLISH : ST_ACCUM;
                end else begin
                    state_next_s = ST_ACCUM;
                end
            end
            ST_PUBLISH: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Next working entries: optional clear, then strict-greater replacement in the bin's band.
    always_comb begin
        for (int k = 0; k < NUM_BANDS; k++) begin
            logic [BIN_W-1:0] base_idx;
            logic [MAG_W-1:0] base_mag;
            if (clear_s) begin
                base_idx = {BIN_W{1'b0}};
                base_mag = {MAG_W{1'b0}};
            end else begin
                base_idx = work_idx_r[k];
                base_mag = work_mag_r[k];
            end
            if (process_s && qualified_s && (band_s == BAND_W'(k)) && (bin_mag > base_mag)) begin
                work_idx_next_s[k] = bin_index;
                work_mag_next_s[k] = bin_mag;
            end else begin
                work_idx_next_s[k] = base_idx;
                work_mag_next_s[k] = base_mag;
            end
        end
    end

    // The published word is taken from the next-state entries so the eop bin is included.
    always_comb begin
        flat_next_s = {FLAT_W{1'b0}};
        for (int k = 0; k < NUM_BANDS; k++) begin
            flat_next_s[k*ENTRY_W +: ENTRY_W] = pack_entry(work_idx_next_s[k], work_mag_next_s[k]);
        end
    end

    // State, working entries and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            maxima_flat_r  <= {FLAT_W{1'b0}};
            maxima_valid_r <= 1'b0;
            frame_abort_r  <= 1'b0;
            for (int k = 0; k < NUM_BANDS; k++) begin
                work_idx_r[k] <= {BIN_W{1'b0}};
                work_mag_r[k] <= {MAG_W{1'b0}};
            end
        end else begin
            state_r        <= state_next_s;
            maxima_valid_r <= publish_s;
            frame_abort_r  <= abort_s;
            for (int k = 0; k < NUM_BANDS; k++) begin
                work_idx_r[k] <= work_idx_next_s[k];
                work_mag_r[k] <= work_mag_next_s[k];
            end
            if (publish_s) begin
                maxima_flat_r <= flat_next_s;
            end else begin
                maxima_flat_r <= maxima_flat_r;
            end
        end
    end

    assign maxima_flat  = maxima_flat_r;
    assign maxima_valid = maxima_valid_r;
    assign frame_abort  = frame_abort_r;

endmodule
